irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Receiving end of the peripheral interrupt lines, including the timer irqs[2:0] pulses.
- Latches per-source pending flags and masks them with per-source enables and per-group 2-bit priority.
- Arbitrates the highest-priority request and presents one stable vector to the CPU through a req/ack handshake.
- Bus-mapped on the same 24-bit I/O bus as the other peripherals.

Parameters:
- IRQ_PRI, 24'h2020, base of 2 priority bytes (8 groups x 2 bits).
- IRQ_ENA, 24'h2023, base of 4 enable bytes (one bit per source).
- IRQ_ACT, 24'h2027, base of 4 pending bytes (read / write-1-to-clear).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  reset, asynchronous, active-low (asserted at 0).
- clk_ce_cpu  in  1  CPU-rate clock enable; all state updates qualify on it.
- bus_write  in  1  register write strobe.
- bus_read  in  1  register read strobe; unused for side effects.
- bus_address_in  in  24  register address.
- bus_data_in  in  8  write data.
- bus_data_out  out  8  read data, combinational, 0 for unmapped addresses.
- irq_in  in  32  source lines, active-high level-or-pulse; bit n = source n.
- cpu_level  in  2  current CPU interrupt mask level.
- irq_req  out  1  interrupt request to the CPU.
- irq_vector  out  5  index of the requested source.
- irq_ack  in  1  CPU accepts the presented vector.

Behaviour:
- Reset values:
  - pri, ena, act all 0; FSM in IDLE.
  - irq_req=0, irq_vector=0.
- Group g = sources 4g..4g+3. Group priority p[g] = pri byte (g>>2), bits [2*(g&3)+1 : 2*(g&3)].
- p[g]=0 masks the whole group.
- Register writes:
  - Committed at a posedge with clk_ce_cpu & bus_write.
  - PRI and ENA: plain write.
  - ACT: write-1-to-clear per bit.
- Pending capture: at each clk_ce_cpu edge, act[n] <= 1 if irq_in[n]=1.
  - Disabled sources still latch pending.
  - Set beats a same-cycle W1C clear.
- Eligible(n) = act[n] & ena[n] & (p[n>>2] > cpu_level).
- Winner:
  - Highest p among eligible sources.
  - Tie goes to the lowest index.
  - Combinational, 32-input.
- FSM, advances only on clk_ce_cpu:
  - IDLE: if any eligible source, latch irq_vector=winner and irq_req<=1, go to REQ.
  - REQ:
    - irq_req held at 1; irq_vector frozen, never changes mid-handshake.
    - On irq_ack: irq_req<=0, go to HOLD.
    - Without ack, if the latched source is no longer eligible (cleared, disabled, group lowered, or cpu_level raised): irq_req<=0, go to IDLE (withdraw).
    - A newly arriving higher-priority source does NOT preempt an outstanding REQ.
  - HOLD: exactly one clk_ce_cpu cycle, lets the CPU update cpu_level; then go to IDLE.
- Ack semantics:
  - Ack does not clear act; software clears it through ACT.
  - irq_ack asserted outside REQ is ignored.
- Latency: source pulse at CE edge k -> act set at k -> irq_req=1 at edge k+1.
- Reset mid-handshake: irq_req drops immediately (asynchronous), all state clears.

Decomposition:
- Shared package (pm_irq_pkg): NUM_IRQ=32, GROUP_SIZE=4, NUM_GROUPS=8, vector width 5, FSM state enum {IDLE, REQ, HOLD}, and the source-index constants used by the top level (timer, RTC, keypad, ...).
- One natural sub-module: irq_priority_encoder, purely combinational. Inputs: eligible vector and group priorities. Outputs: winner index, winner priority, any-valid.

Test Plan:
- Priority and enable path: write PRI[0]=8'h03, ENA byte0=8'h01, cpu_level=0, pulse irq_in[0] one CE -> act[0]=1 same edge; irq_req=1, irq_vector=0 next CE.
- Ack and clear:
  - Continue in REQ, assert irq_ack -> irq_req=0, one HOLD cycle, re-request since act[0] still set.
  - Write 8'h01 to IRQ_ACT -> act[0]=0, no further req.
- Arbitration: sources 1 (group0, p=1) and 5 (group1, p=3) pending together, both enabled -> vector=5. With both in group0 at p=2 -> vector=1 (lowest index).
- Masking:
  - cpu_level=3 with all p<=3 -> irq_req stays 0.
  - Set p=0 for a pending group during REQ -> irq_req withdrawn next CE, FSM back to IDLE.
- Set/clear race: W1C to bit 2 in the same CE cycle as irq_in[2]=1 -> act[2] remains 1. Read IRQ_ACT -> 8'h04.
- Asynchronous reset: drop reset to 0 while in REQ -> irq_req=0 without a clock edge; after release, PRI/ENA/ACT read 0.

Source files
------------

// File: rtl/pm_irq_pkg.sv
// rtl/pm_irq_pkg.sv - shared constants, state type and helpers for the interrupt controller
package pm_irq_pkg;

  localparam int NUM_IRQ    = 32;
  localparam int GROUP_SIZE = 4;
  localparam int NUM_GROUPS = 8;
  localparam int VEC_W      = 5;
  localparam int PRI_W      = 2;

  localparam logic [23:0] IRQ_PRI = 24'h002020;
  localparam logic [23:0] IRQ_ENA = 24'h002023;
  localparam logic [23:0] IRQ_ACT = 24'h002027;

  localparam int SRC_TIMER0 = 0;
  localparam int SRC_TIMER1 = 1;
  localparam int SRC_TIMER2 = 2;
  localparam int SRC_RTC    = 3;
  localparam int SRC_KEYPAD = 4;
  localparam int SRC_UART   = 5;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} irq_state_e;

  // Group g occupies bits [2g+1:2g] of the little-endian priority bytes.
  function automatic logic [PRI_W-1:0] group_pri(input logic [PRI_W*NUM_GROUPS-1:0] pri,
                                                 input int g);
    return pri[PRI_W*g +: PRI_W];
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - picks the highest-priority eligible source, lowest index on ties
module irq_priority_encoder
  import pm_irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0]          eligible_i,
  input  logic [PRI_W*NUM_GROUPS-1:0] group_pri_i,
  output logic [VEC_W-1:0]            winner_o,
  output logic [PRI_W-1:0]            winner_pri_o,
  output logic                        any_o
);

  logic [VEC_W-1:0] win;
  logic [PRI_W-1:0] win_pri;
  logic             found;

  // Scanning downward with >= lets a lower index overwrite an equal-priority winner.
  always_comb begin
    win     = '0;
    win_pri = '0;
    found   = 1'b0;
    for (int n = NUM_IRQ - 1; n >= 0; n--) begin
      if (eligible_i[n] && (!found || group_pri(group_pri_i, n / GROUP_SIZE) >= win_pri)) begin
        found   = 1'b1;
        win_pri = group_pri(group_pri_i, n / GROUP_SIZE);
        win     = VEC_W'(n);
      end
    end
  end

  assign winner_o     = win;
  assign winner_pri_o = win_pri;
  assign any_o        = found;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - pending/enable/priority registers and CPU req/ack handshake
module irq_controller
  import pm_irq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ce_cpu,
  input  logic                bus_write,
  input  logic                bus_read,
  input  logic [23:0]         bus_address_in,
  input  logic [7:0]          bus_data_in,
  output logic [7:0]          bus_data_out,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [1:0]          cpu_level,
  output logic                irq_req,
  output logic [VEC_W-1:0]    irq_vector,
  input  logic                irq_ack
);

  logic [PRI_W*NUM_GROUPS-1:0] pri_q, pri_d;
  logic [NUM_IRQ-1:0]          ena_q, ena_d, act_q, act_d, w1c;
  irq_state_e                  state_q, state_d;
  logic                        req_q, req_d;
  logic [VEC_W-1:0]            vec_q, vec_d;
  logic [NUM_IRQ-1:0]          eligible;
  logic [VEC_W-1:0]            winner;
  logic [PRI_W-1:0]            unused_win_pri;
  logic                        any_eligible;
  logic                        unused_bus_read;

  assign unused_bus_read = bus_read;

  always_comb begin
    pri_d = pri_q;
    ena_d = ena_q;
    w1c   = '0;
    if (bus_write) begin
      for (int b = 0; b < 2; b++)
        if (bus_address_in == IRQ_PRI + 24'(b)) pri_d[8*b +: 8] = bus_data_in;
      for (int b = 0; b < 4; b++) begin
        if (bus_address_in == IRQ_ENA + 24'(b)) ena_d[8*b +: 8] = bus_data_in;
        if (bus_address_in == IRQ_ACT + 24'(b)) w1c[8*b +: 8] = bus_data_in;
      end
    end
    // A line high on the same edge as a clear keeps its pending bit.
    act_d = (act_q & ~w1c) | irq_in;
  end

  always_comb begin
    bus_data_out = '0;
    for (int b = 0; b < 2; b++)
      if (bus_address_in == IRQ_PRI + 24'(b)) bus_data_out = pri_q[8*b +: 8];
    for (int b = 0; b < 4; b++) begin
      if (bus_address_in == IRQ_ENA + 24'(b)) bus_data_out = ena_q[8*b +: 8];
      if (bus_address_in == IRQ_ACT + 24'(b)) bus_data_out = act_q[8*b +: 8];
    end
  end

  always_comb begin
    eligible = '0;
    for (int n = 0; n < NUM_IRQ; n++)
      eligible[n] = act_q[n] & ena_q[n] & (group_pri(pri_q, n / GROUP_SIZE) > cpu_level);
  end

  irq_priority_encoder u_enc (
    .eligible_i   (eligible),
    .group_pri_i  (pri_q),
    .winner_o     (winner),
    .winner_pri_o (unused_win_pri),
    .any_o        (any_eligible)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: if (any_eligible) begin
        vec_d   = winner;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (irq_ack) begin
        req_d   = 1'b0;
        state_d = HOLD;
      end else if (!eligible[vec_q]) begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      HOLD: state_d = IDLE;
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pri_q   <= '0;
      ena_q   <= '0;
      act_q   <= '0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      vec_q   <= '0;
    end else if (clk_ce_cpu) begin
      pri_q   <= pri_d;
      ena_q   <= ena_d;
      act_q   <= act_d;
      state_q <= state_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_vector = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller
module tb_irq_controller;

  localparam logic [23:0] A_PRI0 = 24'h002020;
  localparam logic [23:0] A_PRI1 = 24'h002021;
  localparam logic [23:0] A_GAP  = 24'h002022;
  localparam logic [23:0] A_ENA0 = 24'h002023;
  localparam logic [23:0] A_ENA3 = 24'h002026;
  localparam logic [23:0] A_ACT0 = 24'h002027;
  localparam logic [23:0] A_ACT3 = 24'h00202A;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_ce_cpu = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic [7:0]  bus_data_out;
  logic [31:0] irq_in = '0;
  logic [1:0]  cpu_level = '0;
  logic        irq_req;
  logic [4:0]  irq_vector;
  logic        irq_ack = 1'b0;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .clk_ce_cpu     (clk_ce_cpu),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_in         (irq_in),
    .cpu_level      (cpu_level),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_ack        (irq_ack)
  );

  initial forever #5 clk = ~clk;

  // CE is high for one posedge in four.
  int ce_cnt = 0;
  initial forever begin
    @(negedge clk);
    ce_cnt = (ce_cnt + 1) % 4;
    clk_ce_cpu = (ce_cnt == 0);
  end

  typedef struct { string name; logic [7:0] exp; } rd_exp_t;
  typedef struct { string name; logic [5:0] exp; logic [5:0] mask; } lvl_exp_t;
  typedef struct { string name; logic [4:0] exp; } vec_exp_t;

  rd_exp_t  rd_q[$];
  lvl_exp_t lvl_q[$];
  vec_exp_t vec_q[$];
  rd_exp_t  rd_e;
  lvl_exp_t lvl_e;
  vec_exp_t vec_e;

  int   n_vec = 0;
  int   n_err = 0;
  logic lvl_probe = 1'b0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (bus_read) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got %02h want no read", bus_data_out);
      end else begin
        rd_e = rd_q.pop_front();
        if (bus_data_out !== rd_e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h want %02h", rd_e.name, bus_data_out, rd_e.exp);
        end
      end
    end
    if (lvl_probe) begin
      n_vec++;
      if (lvl_q.size() == 0) begin
        n_err++;
        $display("FAIL lvl_unexpected: got %b/%0d want no probe", irq_req, irq_vector);
      end else begin
        lvl_e = lvl_q.pop_front();
        if ((({irq_req, irq_vector} ^ lvl_e.exp) & lvl_e.mask) != 6'b0) begin
          n_err++;
          $display("FAIL %s: got req=%b vec=%0d want req=%b vec=%0d (mask %b)",
                   lvl_e.name, irq_req, irq_vector, lvl_e.exp[5], lvl_e.exp[4:0], lvl_e.mask);
        end
      end
    end
    if (irq_req === 1'b1 && prev_req !== 1'b1) begin
      n_vec++;
      if (vec_q.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got req rise vec=%0d want no request", irq_vector);
      end else begin
        vec_e = vec_q.pop_front();
        if (irq_vector !== vec_e.exp) begin
          n_err++;
          $display("FAIL %s: got vec=%0d want vec=%0d", vec_e.name, irq_vector, vec_e.exp);
        end
      end
    end
    prev_req = irq_req;
  end

  task automatic tick();
    do @(posedge clk); while (!clk_ce_cpu);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    bus_address_in = a;
    bus_data_in = d;
    bus_write = 1'b1;
    tick();
    bus_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [23:0] a, input logic [7:0] e);
    bus_address_in = a;
    bus_read = 1'b1;
    rd_q.push_back('{name, e});
    @(negedge clk);
    #1;
    bus_read = 1'b0;
  endtask

  task automatic lvl(input string name, input logic req, input logic [4:0] v, input logic chk_v);
    lvl_q.push_back('{name, {req, v}, {1'b1, {5{chk_v}}}});
    lvl_probe = 1'b1;
    @(negedge clk);
    #1;
    lvl_probe = 1'b0;
  endtask

  task automatic expect_vec(input string name, input logic [4:0] v);
    vec_q.push_back('{name, v});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    lvl("reset_out", 1'b0, 5'd0, 1'b1);
    reset = 1'b1;
    rd("reset_pri0", A_PRI0, 8'h00);
    rd("reset_ena0", A_ENA0, 8'h00);
    rd("reset_act0", A_ACT0, 8'h00);

    // Single source, latency and ack/HOLD/re-request.
    wr(A_PRI0, 8'h03);
    wr(A_ENA0, 8'h01);
    irq_in = 32'h1;
    tick();
    irq_in = '0;
    lvl("no_req_at_capture", 1'b0, 5'd0, 1'b0);
    rd("act0_set", A_ACT0, 8'h01);
    expect_vec("first_req_vec", 5'd0);
    tick();
    lvl("req_after_one_ce", 1'b1, 5'd0, 1'b1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    lvl("ack_drops_req", 1'b0, 5'd0, 1'b0);
    tick();
    lvl("hold_idle_no_req", 1'b0, 5'd0, 1'b0);
    expect_vec("rereq_vec", 5'd0);
    tick();
    lvl("rereq_level", 1'b1, 5'd0, 1'b1);
    wr(A_ACT0, 8'h01);
    lvl("req_held_on_clear_edge", 1'b1, 5'd0, 1'b1);
    tick();
    lvl("withdraw_after_clear", 1'b0, 5'd0, 1'b0);
    rd("act0_cleared", A_ACT0, 8'h00);
    tick();
    lvl("no_further_req", 1'b0, 5'd0, 1'b0);

    // Arbitration: higher group wins, then tie goes to lowest index.
    wr(A_PRI0, 8'h0D);
    wr(A_ENA0, 8'h22);
    irq_in = 32'h22;
    tick();
    irq_in = '0;
    expect_vec("arb_high_pri", 5'd5);
    tick();
    rd("arb_act0", A_ACT0, 8'h22);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    wr(A_ACT0, 8'h22);
    tick();
    lvl("arb_cleared", 1'b0, 5'd0, 1'b0);
    wr(A_PRI0, 8'h02);
    wr(A_ENA0, 8'h0A);
    irq_in = 32'h0A;
    tick();
    irq_in = '0;
    expect_vec("arb_tie_low_idx", 5'd1);
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    wr(A_ACT0, 8'h0A);
    tick();
    lvl("tie_cleared", 1'b0, 5'd0, 1'b0);

    // Masking by cpu_level, then withdraw on group priority lowered.
    wr(A_PRI0, 8'hFF);
    wr(A_ENA0, 8'h01);
    cpu_level = 2'd3;
    irq_in = 32'h1;
    tick();
    irq_in = '0;
    tick();
    tick();
    lvl("cpu_level_masks", 1'b0, 5'd0, 1'b0);
    cpu_level = 2'd2;
    expect_vec("unmasked_vec", 5'd0);
    tick();
    wr(A_PRI0, 8'hFC);
    lvl("req_held_on_pri_edge", 1'b1, 5'd0, 1'b1);
    tick();
    lvl("withdraw_pri0", 1'b0, 5'd0, 1'b0);
    tick();
    lvl("masked_stays_idle", 1'b0, 5'd0, 1'b0);
    wr(A_ACT0, 8'h01);
    cpu_level = 2'd0;

    // Set beats same-cycle clear; unmapped addresses read zero.
    irq_in = 32'h4;
    wr(A_ACT0, 8'h04);
    irq_in = '0;
    rd("set_beats_clear", A_ACT0, 8'h04);
    wr(A_ACT0, 8'h04);
    rd("w1c_bit2", A_ACT0, 8'h00);
    rd("unmapped_gap", A_GAP, 8'h00);
    rd("unmapped_low", 24'h00201F, 8'h00);
    rd("unmapped_high", 24'h00202B, 8'h00);

    // Source 31 (top byte, group 7), no preemption, asynchronous reset.
    wr(A_PRI1, 8'h80);
    wr(A_ENA3, 8'h80);
    irq_in = 32'h8000_0000;
    tick();
    irq_in = '0;
    expect_vec("src31_vec", 5'd31);
    tick();
    rd("act3", A_ACT3, 8'h80);
    rd("ena3", A_ENA3, 8'h80);
    rd("pri1", A_PRI1, 8'h80);
    wr(A_PRI0, 8'h03);
    irq_in = 32'h1;
    tick();
    irq_in = '0;
    tick();
    lvl("no_preempt", 1'b1, 5'd31, 1'b1);
    #2;
    reset = 1'b0;
    lvl("async_reset_drop", 1'b0, 5'd0, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    rd("post_reset_pri0", A_PRI0, 8'h00);
    rd("post_reset_pri1", A_PRI1, 8'h00);
    rd("post_reset_ena0", A_ENA0, 8'h00);
    tick();
    rd("post_reset_ena3", A_ENA3, 8'h00);
    rd("post_reset_act0", A_ACT0, 8'h00);
    rd("post_reset_act3", A_ACT3, 8'h00);
    tick();
    tick();
    lvl("post_reset_idle", 1'b0, 5'd0, 1'b1);

    if (vec_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL req_missing: got %0d pending want 0", vec_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
